// File: rtl/dcache_tag_pkg.sv
// Shared types for the data-cache tag store: request opcodes, the sweep
// state machine encoding and the default-geometry tag entry layout.
package dcache_tag_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FILL   = 2'd1,
        OP_INVAL  = 2'd2,
        OP_FLUSH  = 2'd3
    } tag_op_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_FLUSH = 2'd2
    } sweep_state_e;

    // Entry layout at the default 20-bit tag width. The array re-declares the
    // same layout sized by its TAG_WIDTH parameter, since package types cannot
    // follow a module parameter.
    localparam int TAG_WIDTH_DEF = 20;

    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [TAG_WIDTH_DEF-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/dcache_plru_tree.sv
// Combinational tree-PLRU helper for one cache set.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half); a node bit of 0
// steers the victim towards the lower half. Victim choice prefers the
// lowest-index invalid way, otherwise it follows the tree.
module dcache_plru_tree #(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int NODES    = NUM_WAYS - 1
) (
    input  logic [NODES-1:0]    plru,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic                touch_en,
    input  logic [WAY_W-1:0]    touch_way,
    output logic [WAY_W-1:0]    victim_way,
    output logic [NODES-1:0]    plru_next
);

    localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1;

    logic [WAY_W-1:0]  tree_way;
    logic [WAY_W-1:0]  free_way;
    logic              any_free;
    logic [NODE_W-1:0] vnode;
    logic [NODE_W-1:0] tnode;
    logic [NODES-1:0]  nxt;
    logic              dir;

    // Walk the tree from the root; each node bit is one bit of the victim way
    always_comb begin
        tree_way = '0;
        vnode    = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            tree_way[WAY_W-1-lvl] = plru[vnode];
            vnode = NODE_W'(2 * int'(vnode) + 1 + int'(plru[vnode]));
        end
    end

    // Lowest-index invalid way, if any
    always_comb begin
        any_free = 1'b0;
        free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                any_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign victim_way = any_free ? free_way : tree_way;

    // Touch: every node on the path to the touched way points away from it
    always_comb begin
        nxt   = plru;
        tnode = '0;
        dir   = 1'b0;
        if (touch_en) begin
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                dir        = touch_way[WAY_W-1-lvl];
                nxt[tnode] = ~dir;
                tnode      = NODE_W'(2 * int'(tnode) + 1 + int'(dir));
            end
        end
        plru_next = nxt;
    end

endmodule

// File: rtl/dcache_tag_array.sv
// N-way set-associative tag store with per-set tree-PLRU state.
// Requests are accepted in READY, the set is read on the accept edge and the
// response (hit way / victim) is presented the following cycle. A sweep state
// machine clears every set after reset and after a FLUSH request.
// Optional feature: define DCACHE_TAG_PARITY_EN to store an even-parity bit per
// way; bad-parity ways are treated as invalid on LOOKUP and flag rsp_par_err.
module dcache_tag_array
    import dcache_tag_pkg::*;
#(
    parameter  int NUM_WAYS  = 4,
    parameter  int NUM_SETS  = 256,
    parameter  int TAG_WIDTH = 20,
    localparam int IDX_W     = $clog2(NUM_SETS),
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [IDX_W-1:0]     req_idx,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [WAY_W-1:0]     req_way,
    input  logic                 req_dirty,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [WAY_W-1:0]     rsp_hit_way,
    output logic                 rsp_dirty,
    output logic [WAY_W-1:0]     rsp_victim_way,
    output logic                 rsp_victim_valid,
    output logic                 rsp_victim_dirty,
    output logic [TAG_WIDTH-1:0] rsp_victim_tag,
    output logic                 rsp_par_err
);

    localparam int NODES = NUM_WAYS - 1;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q;
    logic             sweeping;
    logic             accept;
    logic             wr_en;
    tag_op_e          op_in;
    entry_t           wr_entry;

    entry_t           mem_q  [NUM_SETS][NUM_WAYS];
    logic [NODES-1:0] plru_q [NUM_SETS];

    logic                 vld_p1;
    tag_op_e              op_p1;
    logic [IDX_W-1:0]     idx_p1;
    logic [TAG_WIDTH-1:0] tag_p1;
    logic [WAY_W-1:0]     way_p1;
    logic                 dirty_p1;
    entry_t               rd_p1 [NUM_WAYS];

    logic [NUM_WAYS-1:0] way_bad;
    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] way_match;
    logic                lk_hit;
    logic [WAY_W-1:0]    lk_way;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                hit_dirty;
    logic                touch_en;
    logic [WAY_W-1:0]    touch_way;
    logic [NODES-1:0]    plru_cur;
    logic [NODES-1:0]    plru_nxt;
    logic [WAY_W-1:0]    victim_way;

`ifdef DCACHE_TAG_PARITY_EN
    logic par_q  [NUM_SETS][NUM_WAYS];
    logic par_p1 [NUM_WAYS];

    function automatic logic entry_parity(input entry_t e);
        return ^e;
    endfunction
`endif

    assign op_in  = tag_op_e'(req_op);
    assign accept = req_valid && req_ready;
    assign wr_en  = accept && (op_in == OP_FILL || op_in == OP_INVAL);

    // Sweep state register and set counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (sweeping) begin
                sweep_idx_q <= sweep_idx_q + 1'b1;
            end
        end
    end

    // Next state: sweep ends after the last set, FLUSH starts a new sweep
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT, ST_FLUSH: if (sweep_idx_q == IDX_W'(NUM_SETS - 1)) state_d = ST_READY;
            ST_READY:          if (accept && op_in == OP_FLUSH) state_d = ST_FLUSH;
            default:           state_d = ST_INIT;
        endcase
    end

    // FSM outputs: requests only accepted while not sweeping
    always_comb begin
        req_ready = 1'b0;
        sweeping  = 1'b0;
        case (state_q)
            ST_READY:          req_ready = 1'b1;
            ST_INIT, ST_FLUSH: sweeping  = 1'b1;
            default:           ;
        endcase
    end

    // Entry written by FILL (valid) or INVAL (invalid, clean)
    always_comb begin
        wr_entry.valid = (op_in == OP_FILL);
        wr_entry.dirty = (op_in == OP_FILL) && req_dirty;
        wr_entry.tag   = req_tag;
    end

    // Tag storage: sweep clears a whole set, FILL/INVAL write one way
    always_ff @(posedge clk) begin
        if (sweeping) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                mem_q[sweep_idx_q][w] <= '0;
`ifdef DCACHE_TAG_PARITY_EN
                par_q[sweep_idx_q][w] <= 1'b0;
`endif
            end
        end else if (wr_en) begin
            mem_q[req_idx][req_way] <= wr_entry;
`ifdef DCACHE_TAG_PARITY_EN
            par_q[req_idx][req_way] <= entry_parity(wr_entry);
`endif
        end
    end

    // ---- stage 1: accept edge, control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            op_p1  <= OP_LOOKUP;
        end else begin
            vld_p1 <= accept && (op_in != OP_FLUSH);
            if (accept) begin
                op_p1 <= op_in;
            end
        end
    end

    // Stage 1 data: request fields and the pre-write contents of the set
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= req_idx;
            tag_p1   <= req_tag;
            way_p1   <= req_way;
            dirty_p1 <= req_dirty;
            for (int w = 0; w < NUM_WAYS; w++) begin
                rd_p1[w] <= mem_q[req_idx][w];
`ifdef DCACHE_TAG_PARITY_EN
                par_p1[w] <= par_q[req_idx][w];
`endif
            end
        end
    end

    // ---- stage 2: compare, victim select, PLRU update ----
    // Per-way effective valid (bad parity counts as invalid on LOOKUP) and tag match
    always_comb begin
        way_bad = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef DCACHE_TAG_PARITY_EN
            way_bad[w] = (op_p1 == OP_LOOKUP) && (entry_parity(rd_p1[w]) != par_p1[w]);
`endif
            way_valid[w] = rd_p1[w].valid && !way_bad[w];
            way_match[w] = way_valid[w] && (rd_p1[w].tag == tag_p1);
        end
    end

    // Lowest-index matching way
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    // Hit fields and PLRU touch per opcode
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_dirty = 1'b0;
        touch_en  = 1'b0;
        touch_way = '0;
        case (op_p1)
            OP_LOOKUP: begin
                hit       = lk_hit;
                hit_way   = lk_way;
                hit_dirty = lk_hit && rd_p1[lk_way].dirty;
                touch_en  = lk_hit;
                touch_way = lk_way;
            end
            OP_FILL: begin
                hit       = 1'b1;
                hit_way   = way_p1;
                hit_dirty = dirty_p1;
                touch_en  = 1'b1;
                touch_way = way_p1;
            end
            default: ;
        endcase
    end

    assign plru_cur = plru_q[idx_p1];

    dcache_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .plru       (plru_cur),
        .valid      (way_valid),
        .touch_en   (vld_p1 && touch_en),
        .touch_way  (touch_way),
        .victim_way (victim_way),
        .plru_next  (plru_nxt)
    );

    // PLRU state: cleared by reset and sweep, updated at the end of stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (sweeping) begin
            plru_q[sweep_idx_q] <= '0;
        end else if (vld_p1) begin
            plru_q[idx_p1] <= plru_nxt;
        end
    end

    // Response outputs, held at zero when no response is present
    always_comb begin
        rsp_valid        = vld_p1;
        rsp_hit          = vld_p1 && hit;
        rsp_hit_way      = vld_p1 ? hit_way : '0;
        rsp_dirty        = vld_p1 && hit_dirty;
        rsp_victim_way   = vld_p1 ? victim_way : '0;
        rsp_victim_valid = vld_p1 && way_valid[victim_way];
        rsp_victim_dirty = vld_p1 && way_valid[victim_way] && rd_p1[victim_way].dirty;
        rsp_victim_tag   = vld_p1 ? rd_p1[victim_way].tag : '0;
`ifdef DCACHE_TAG_PARITY_EN
        rsp_par_err      = vld_p1 && (|way_bad);
`else
        rsp_par_err      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dcache_tag_array.sv
// Self-checking bench for dcache_tag_array (4 ways, 16 sets, 8-bit tags).
// A behavioural model of the tag store and 4-way tree-PLRU produces the
// expected response for every request; a monitor pops and compares it when
// the response is due.
`timescale 1ns/1ps
module tb_dcache_tag_array;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [3:0]    req_idx = '0;
    logic [TW-1:0] req_tag = '0;
    logic [1:0]    req_way = '0;
    logic          req_dirty = 1'b0;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [1:0]    rsp_hit_way;
    logic          rsp_dirty;
    logic [1:0]    rsp_victim_way;
    logic          rsp_victim_valid;
    logic          rsp_victim_dirty;
    logic [TW-1:0] rsp_victim_tag;
    logic          rsp_par_err;

    dcache_tag_array #(
        .NUM_WAYS  (NW),
        .NUM_SETS  (NS),
        .TAG_WIDTH (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_idx          (req_idx),
        .req_tag          (req_tag),
        .req_way          (req_way),
        .req_dirty        (req_dirty),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_hit_way      (rsp_hit_way),
        .rsp_dirty        (rsp_dirty),
        .rsp_victim_way   (rsp_victim_way),
        .rsp_victim_valid (rsp_victim_valid),
        .rsp_victim_dirty (rsp_victim_dirty),
        .rsp_victim_tag   (rsp_victim_tag),
        .rsp_par_err      (rsp_par_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          hit;
        logic [1:0]    hit_way;
        logic          dirty;
        logic [1:0]    vway;
        logic          vvalid;
        logic          vdirty;
        logic [TW-1:0] vtag;
        logic          par_err;
        int            due;
    } exp_t;

    exp_t q[$];

    // Reference model state
    logic          m_valid [NS][NW];
    logic          m_dirty [NS][NW];
    logic          m_bad   [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    logic [2:0]    m_plru  [NS];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Bit 0 root, bit 1 lower pair (ways 0/1), bit 2 upper pair (ways 2/3)
    function automatic logic [1:0] m_tree_victim(input logic [2:0] p);
        if (p[0]) return p[2] ? 2'd3 : 2'd2;
        else      return p[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r = p;
        case (w)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < NS; s++) begin
            m_plru[s] = 3'b000;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_bad[s][w]   = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
    endtask

    // Drive one request for a cycle; expected response comes from the model
    task automatic issue(input logic [1:0] op, input int idx, input logic [TW-1:0] tag,
                         input int way, input logic dirty);
        exp_t e;
        logic ev [NW];
        int   v;
        req_valid = 1'b1;
        req_op    = op;
        req_idx   = 4'(idx);
        req_tag   = tag;
        req_way   = 2'(way);
        req_dirty = dirty;
        if (op == 2'd3) begin
            m_clear();
        end else begin
            e.hit = 1'b0; e.hit_way = 2'd0; e.dirty = 1'b0; e.par_err = 1'b0;
            for (int w = 0; w < NW; w++) begin
                ev[w] = m_valid[idx][w] && !(op == 2'd0 && m_bad[idx][w]);
                if (op == 2'd0 && m_bad[idx][w]) e.par_err = 1'b1;
            end
            v = -1;
            for (int w = 0; w < NW; w++) if (v < 0 && !ev[w]) v = w;
            e.vway   = (v >= 0) ? 2'(v) : m_tree_victim(m_plru[idx]);
            e.vvalid = ev[e.vway];
            e.vdirty = ev[e.vway] && m_dirty[idx][e.vway];
            e.vtag   = m_tag[idx][e.vway];
            if (op == 2'd0) begin
                for (int w = NW - 1; w >= 0; w--) begin
                    if (ev[w] && m_tag[idx][w] == tag) begin
                        e.hit = 1'b1; e.hit_way = 2'(w);
                    end
                end
                if (e.hit) begin
                    e.dirty      = m_dirty[idx][e.hit_way];
                    m_plru[idx]  = m_touch(m_plru[idx], e.hit_way);
                end
            end else if (op == 2'd1) begin
                e.hit = 1'b1; e.hit_way = 2'(way); e.dirty = dirty;
                m_valid[idx][way] = 1'b1; m_dirty[idx][way] = dirty;
                m_tag[idx][way] = tag;    m_bad[idx][way] = 1'b0;
                m_plru[idx] = m_touch(m_plru[idx], 2'(way));
            end else begin
                m_valid[idx][way] = 1'b0; m_dirty[idx][way] = 1'b0;
                m_tag[idx][way] = tag;    m_bad[idx][way] = 1'b0;
            end
            e.due = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input int expn, input string name);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n), 32'(expn));
    endtask

    // Response monitor: compare the queue head in the cycle it is due
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1'b1));
            chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
            chk("rsp_hit_way", 32'(rsp_hit_way), 32'(e.hit_way));
            chk("rsp_dirty", 32'(rsp_dirty), 32'(e.dirty));
            chk("rsp_victim_way", 32'(rsp_victim_way), 32'(e.vway));
            chk("rsp_victim_valid", 32'(rsp_victim_valid), 32'(e.vvalid));
            chk("rsp_victim_dirty", 32'(rsp_victim_dirty), 32'(e.vdirty));
            if (e.vvalid) chk("rsp_victim_tag", 32'(rsp_victim_tag), 32'(e.vtag));
            chk("rsp_par_err", 32'(rsp_par_err), 32'(e.par_err));
        end else if (rsp_valid) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'(1'b0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'(1'b0));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("reset_rsp_hit", 32'(rsp_hit), 32'(1'b0));
        chk("reset_rsp_victim_way", 32'(rsp_victim_way), 32'(2'd0));
        chk("reset_rsp_victim_tag", 32'(rsp_victim_tag), 32'(8'd0));
        chk("reset_rsp_par_err", 32'(rsp_par_err), 32'(1'b0));
        rst = 1'b0;
        wait_ready(16, "init_sweep_cycles");

        // Empty set
        issue(2'd0, 4, 8'h11, 0, 1'b0);

        // Fill then immediate lookup of the same set
        issue(2'd1, 3, 8'hA5, 2, 1'b0);
        issue(2'd0, 3, 8'hA5, 0, 1'b0);

        // Full set, PLRU victim after hitting way 0
        for (int w = 0; w < NW; w++) issue(2'd1, 5, 8'(w + 1), w, 1'b0);
        issue(2'd0, 5, 8'h01, 0, 1'b0);
        issue(2'd0, 5, 8'h09, 0, 1'b0);

        // Invalidate a dirty way, it becomes the preferred victim
        for (int w = 0; w < NW; w++) issue(2'd1, 7, 8'(8'h70 + w), w, (w == 1));
        issue(2'd2, 7, 8'h00, 1, 1'b0);
        issue(2'd0, 7, 8'h77, 0, 1'b0);
        issue(2'd0, 7, 8'h73, 0, 1'b0);

        // Dirty hit
        issue(2'd1, 8, 8'h42, 1, 1'b1);
        issue(2'd0, 8, 8'h42, 0, 1'b0);

        // Mixed random traffic on a few sets
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 2)), $urandom_range(0, 3),
                  8'(8'h10 + $urandom_range(0, 5)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
        end

`ifdef DCACHE_TAG_PARITY_EN
        // Corrupt one stored tag bit; lookup must report a parity error, no hit
        issue(2'd1, 9, 8'h3C, 0, 1'b0);
        @(negedge clk);
        dut.mem_q[9][0].tag[0] = ~dut.mem_q[9][0].tag[0];
        m_bad[9][0] = 1'b1;
        issue(2'd0, 9, 8'h3C, 0, 1'b0);
`endif

        // FLUSH right behind a lookup: lookup response still issues
        issue(2'd0, 5, 8'h02, 0, 1'b0);
        issue(2'd3, 0, 8'h00, 0, 1'b0);
        chk("flush_ready_low", 32'(req_ready), 32'(1'b0));
        wait_ready(16, "flush_sweep_cycles");
        issue(2'd0, 3, 8'hA5, 0, 1'b0);
        issue(2'd0, 5, 8'h01, 0, 1'b0);
        issue(2'd0, 7, 8'h70, 0, 1'b0);

        // Reset in the middle of a sweep restarts it
        issue(2'd3, 0, 8'h00, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_sweep_ready", 32'(req_ready), 32'(1'b0));
        rst = 1'b0;
        m_clear();
        wait_ready(16, "rst_mid_sweep_cycles");
        issue(2'd0, 8, 8'h42, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
